hamming_pair_scheduler: RTL and testbench

Control block that owns two 11-bit Hamming codewords (7 data + 4 parity each) and sequences encode, fault injection, and check/correct operations on them. One registered syndrome unit is shared between the two lanes and time-multiplexed by an FSM. Operator commands arrive on the board's active-low push keys; the data word and injection position come from the slide switches. Results and status drive the red LEDs directly.

---
 rtl/hamming_pair_scheduler_if.sv | 15 +
 rtl/hamming_pair_scheduler.sv | 172 +++++++++++++++++
 tb/tb_hamming_pair_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_pair_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pair_scheduler_if
// Description : Board I/O bundle: push keys, slide switches and red LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming_pair_scheduler_if;
    logic [3:0]  key;
    logic [17:0] sw;
    logic [17:0] LEDR;

    modport master (output key, output sw, input LEDR);
    modport slave  (input key, input sw, output LEDR);
endinterface
`default_nettype wire

// File: rtl/hamming_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pair_scheduler
// Description : Two-lane Hamming(11,7) encode/inject/correct sequencer that
//               time-shares one registered syndrome unit.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_pair_scheduler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hamming_pair_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_INJ  = 3'd2,
        S_CHK0 = 3'd3,
        S_FIX0 = 3'd4,
        S_CHK1 = 3'd5,
        S_FIX1 = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // Bit index equals codeword position (1..11).
    function automatic logic [11:1] f_encode(input logic [6:0] d);
        logic [11:1] cw;
        cw     = '0;
        cw[3]  = d[0];
        cw[5]  = d[1];
        cw[6]  = d[2];
        cw[7]  = d[3];
        cw[9]  = d[4];
        cw[10] = d[5];
        cw[11] = d[6];
        cw[1]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        cw[2]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        cw[4]  = d[1] ^ d[2] ^ d[3];
        cw[8]  = d[4] ^ d[5] ^ d[6];
        return cw;
    endfunction

    function automatic logic [6:0] f_data(input logic [11:1] cw);
        return {cw[11], cw[10], cw[9], cw[7], cw[6], cw[5], cw[3]};
    endfunction

    function automatic logic [3:0] f_syndrome(input logic [11:1] cw);
        logic [11:1] w_ref;
        w_ref = f_encode(f_data(cw));
        return {w_ref[8] ^ cw[8], w_ref[4] ^ cw[4], w_ref[2] ^ cw[2], w_ref[1] ^ cw[1]};
    endfunction

    // Positions outside 1..11 yield an empty mask, so they flip nothing.
    function automatic logic [11:1] f_mask(input logic [3:0] pos);
        logic [11:1] m;
        for (int i = 1; i <= 11; i++) begin
            m[i] = (pos == 4'(i));
        end
        return m;
    endfunction

    logic [3:0] w_pulse;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_key
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '1;
                    r_prev <= 1'b1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], bus.key[k]};
                    r_prev <= r_sync[SYNC_STAGES-1];
                end
            end

            assign w_pulse[k] = r_prev & ~r_sync[SYNC_STAGES-1];
        end
    endgenerate

    state_t      r_state;
    logic [11:1] r_cw0;
    logic [11:1] r_cw1;
    logic [3:0]  r_syn;
    logic [3:0]  r_pos;
    logic        r_lane;
    logic        r_f0;
    logic        r_f1;
    logic        r_fu;
    logic        w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cw0   <= '0;
            r_cw1   <= '0;
            r_syn   <= '0;
            r_pos   <= '0;
            r_lane  <= 1'b0;
            r_f0    <= 1'b0;
            r_f1    <= 1'b0;
            r_fu    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pulse[0]) begin
                        r_state <= S_LOAD;
                    end else if (w_pulse[3]) begin
                        r_f0    <= 1'b0;
                        r_f1    <= 1'b0;
                        r_fu    <= 1'b0;
                        r_state <= S_CHK0;
                    end else if (w_pulse[1] || w_pulse[2]) begin
                        r_lane  <= ~w_pulse[1];
                        r_pos   <= bus.sw[17:14];
                        r_state <= S_INJ;
                    end
                end
                S_LOAD: begin
                    r_cw0   <= f_encode(bus.sw[6:0]);
                    r_cw1   <= f_encode(bus.sw[13:7]);
                    r_f0    <= 1'b0;
                    r_f1    <= 1'b0;
                    r_fu    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_INJ: begin
                    if (r_lane) r_cw1 <= r_cw1 ^ f_mask(r_pos);
                    else        r_cw0 <= r_cw0 ^ f_mask(r_pos);
                    r_state <= S_IDLE;
                end
                S_CHK0: begin
                    r_syn   <= f_syndrome(r_cw0);
                    r_state <= S_FIX0;
                end
                S_FIX0: begin
                    if (r_syn >= 4'd12) begin
                        r_fu <= 1'b1;
                    end else if (r_syn != 4'd0) begin
                        r_cw0 <= r_cw0 ^ f_mask(r_syn);
                        r_f0  <= 1'b1;
                    end
                    r_state <= S_CHK1;
                end
                S_CHK1: begin
                    r_syn   <= f_syndrome(r_cw1);
                    r_state <= S_FIX1;
                end
                S_FIX1: begin
                    if (r_syn >= 4'd12) begin
                        r_fu <= 1'b1;
                    end else if (r_syn != 4'd0) begin
                        r_cw1 <= r_cw1 ^ f_mask(r_syn);
                        r_f1  <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_busy   = (r_state != S_IDLE);
    assign bus.LEDR = {r_fu, r_f1, r_f0, w_busy, f_data(r_cw1), f_data(r_cw0)};

endmodule
`default_nettype wire

// File: tb/tb_hamming_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_pair_scheduler
// Description : Scoreboard bench for hamming_pair_scheduler with a
//               position-XOR Hamming reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_pair_scheduler;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamming_pair_scheduler_if bus_if ();

    hamming_pair_scheduler #(.SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [17:0] exp_q [$];

    // Model codewords: bit index = position, bit 0 unused.
    logic [11:0] m_cw [2];
    logic        m_f0, m_f1, m_fu;

    // A valid codeword has the XOR of its set-bit positions equal to zero.
    function automatic logic [3:0] m_syn(input logic [11:0] cw);
        int s = 0;
        for (int i = 1; i <= 11; i++) if (cw[i]) s = s ^ i;
        return 4'(s);
    endfunction

    function automatic logic [11:0] m_enc(input logic [6:0] d);
        int pos [7];
        logic [11:0] cw;
        logic [3:0]  s;
        pos = '{3, 5, 6, 7, 9, 10, 11};
        cw  = '0;
        for (int i = 0; i < 7; i++) cw[pos[i]] = d[i];
        s = m_syn(cw);
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        return cw;
    endfunction

    function automatic logic [6:0] m_data(input logic [11:0] cw);
        int pos [7];
        logic [6:0] d;
        pos = '{3, 5, 6, 7, 9, 10, 11};
        for (int i = 0; i < 7; i++) d[i] = cw[pos[i]];
        return d;
    endfunction

    function automatic logic [17:0] m_led();
        return {m_fu, m_f1, m_f0, 1'b0, m_data(m_cw[1]), m_data(m_cw[0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Every accepted command ends with busy falling; that is the output event.
    initial begin : monitor
        logic prev_busy;
        logic b;
        logic [17:0] e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            b = bus_if.LEDR[14];
            if (rst_n && prev_busy && !b) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_op", bus_if.LEDR, 18'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("op_result", bus_if.LEDR, e);
                end
            end
            prev_busy = rst_n ? b : 1'b0;
        end
    end

    task automatic press(input logic [3:0] mask);
        bus_if.key = ~mask;
        repeat (6) @(negedge clk);
        bus_if.key = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    task automatic model_reset();
        m_cw[0] = '0;
        m_cw[1] = '0;
        m_f0 = 1'b0;
        m_f1 = 1'b0;
        m_fu = 1'b0;
    endtask

    task automatic model_load(input logic [13:0] d);
        m_cw[0] = m_enc(d[6:0]);
        m_cw[1] = m_enc(d[13:7]);
        m_f0 = 1'b0;
        m_f1 = 1'b0;
        m_fu = 1'b0;
    endtask

    task automatic model_check();
        logic [3:0] s;
        m_f0 = 1'b0;
        m_f1 = 1'b0;
        m_fu = 1'b0;
        for (int l = 0; l < 2; l++) begin
            s = m_syn(m_cw[l]);
            if (s >= 4'd12) begin
                m_fu = 1'b1;
            end else if (s != 4'd0) begin
                m_cw[l][s] = ~m_cw[l][s];
                if (l == 0) m_f0 = 1'b1;
                else        m_f1 = 1'b1;
            end
        end
    endtask

    task automatic do_load(input logic [13:0] d);
        bus_if.sw[13:0] = d;
        model_load(d);
        exp_q.push_back(m_led());
        press(4'b0001);
    endtask

    task automatic do_inj(input int lane, input logic [3:0] pos);
        bus_if.sw[17:14] = pos;
        if (pos >= 4'd1 && pos <= 4'd11) m_cw[lane][pos] = ~m_cw[lane][pos];
        exp_q.push_back(m_led());
        press(lane == 1 ? 4'b0100 : 4'b0010);
    endtask

    task automatic do_chk();
        model_check();
        exp_q.push_back(m_led());
        press(4'b1000);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        bus_if.key = 4'hF;
        bus_if.sw  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ledr", bus_if.LEDR, 18'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_load(14'h0055);
        check("load_lane0", bus_if.LEDR[6:0], 7'h55);
        check("load_lane1_flags", {bus_if.LEDR[17:14], bus_if.LEDR[13:7]}, 11'h0);

        do_inj(0, 4'd5);
        check("inj_d1", bus_if.LEDR[6:0], 7'h57);
        do_chk();
        check("fix_lane0", bus_if.LEDR[17:15], 3'b001);

        do_load(14'h0055);
        do_inj(1, 4'd8);
        do_chk();
        check("fix_p8_lane1", bus_if.LEDR[17:15], 3'b010);

        do_load(14'h0055);
        do_inj(0, 4'd4);
        do_inj(0, 4'd8);
        do_chk();
        check("uncorrectable", bus_if.LEDR[17:15], 3'b100);
        do_chk();
        check("uncorrectable_again", bus_if.LEDR[17], 1'b1);

        do_inj(0, 4'd0);
        do_inj(1, 4'd13);
        check("noop_positions", bus_if.LEDR[13:0], {7'h0, m_data(m_cw[0])});

        // Inject pressed while a check is in flight must be dropped.
        do_load(14'h1A33);
        do_inj(1, 4'd10);
        model_check();
        exp_q.push_back(m_led());
        bus_if.sw[17:14] = 4'd3;
        bus_if.key = ~4'b1000;
        repeat (2) @(negedge clk);
        bus_if.key = ~4'b1010;
        repeat (8) @(negedge clk);
        bus_if.key = 4'hF;
        repeat (10) @(negedge clk);

        // Load and check together: only the load runs.
        do_inj(0, 4'd7);
        bus_if.sw[13:0] = 14'h2B4C;
        model_load(14'h2B4C);
        exp_q.push_back(m_led());
        press(4'b1001);

        // Reset while FIX0 is active.
        do_load(14'h1234);
        do_inj(1, 4'd6);
        bus_if.key = ~4'b1000;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_op", bus_if.LEDR, 18'h0);
        bus_if.key = 4'hF;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_load(14'h0055);
        check("load_after_reset", bus_if.LEDR[6:0], 7'h55);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       do_load(14'($urandom));
                1:       do_inj(0, 4'($urandom_range(0, 15)));
                2:       do_inj(1, 4'($urandom_range(0, 15)));
                default: do_chk();
            endcase
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
